// File: rtl/debug_unit_ctrl_if.sv
// Bus between the debug-unit controller and its surroundings (UART rx/tx and
// the cpu_core imem/enable/reset ports).
//   master : the controller side (drives o_*, samples i_*)
//   slave  : the environment side (drives i_*, samples o_*)
// Parameters must match the controller instance they connect to.
interface debug_unit_ctrl_if #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8
);
  logic [7:0]                 i_rx_data;
  logic                       i_rx_valid;
  logic                       i_halt;
  logic                       i_tx_done;
  logic [7:0]                 o_tx_data;
  logic                       o_tx_start;
  logic [NB_INSTRUCTION-1:0]  o_imem_data;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr;
  logic [1:0]                 o_mem_wsize;
  logic                       o_imem_wen;
  logic                       o_cpu_en;
  logic                       o_cpu_rst;
  logic                       o_busy;

  modport master (
    input  i_rx_data, i_rx_valid, i_halt, i_tx_done,
    output o_tx_data, o_tx_start, o_imem_data, o_imem_waddr, o_mem_wsize,
           o_imem_wen, o_cpu_en, o_cpu_rst, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_halt, i_tx_done,
    input  o_tx_data, o_tx_start, o_imem_data, o_imem_waddr, o_mem_wsize,
           o_imem_wen, o_cpu_en, o_cpu_rst, o_busy
  );
endinterface

// File: rtl/debug_unit_ctrl.sv
// Debug-unit controller. Decodes single-byte commands from the UART receiver
// and sequences the core: program load into imem ('L'), single step ('S'),
// continuous run until halt or break ('C'), core reset ('R'). Each command
// ends with one status byte to the UART transmitter (ACK 0x06, NAK 0x15,
// halted 'H').
// Ports:
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : debug_unit_ctrl_if.master (rx byte stream, tx status byte,
//              imem write port, core enable/reset, busy)
// Optional feature: define DEBUG_UNIT_TIMEOUT_EN to abort a stalled program
// load with NAK after TIMEOUT_CYCLES cycles without a received byte.
module debug_unit_ctrl #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic             clk,
  input  logic             i_rst_n,
  debug_unit_ctrl_if.master bus
);

  localparam int MAX_WORDS = (2**IMEM_ADDR_WIDTH) / 4;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_RST  = 8'h52;
  localparam logic [7:0] BRK      = 8'h03;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] HALTED   = 8'h48;

  // Byte assembly below assumes exactly four bytes per word.
  if (NB_INSTRUCTION != 32) begin : g_chk_nb
    $error("debug_unit_ctrl: NB_INSTRUCTION must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("debug_unit_ctrl: TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_DATA, STEP, RUN, CPU_RST, SEND, WAIT_TX
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_start_q, tx_start_d;
  logic [NB_INSTRUCTION-1:0]  imem_data_q, imem_data_d;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                       wen_q, wen_d;
  logic                       cpu_en_q, cpu_en_d;
  logic                       cpu_rst_q, cpu_rst_d;
  logic [NB_INSTRUCTION-1:0]  word_q, word_d;
  logic [7:0]                 idx_q, idx_d;
  logic [1:0]                 bcnt_q, bcnt_d;
  logic [7:0]                 nwords_q, nwords_d;
  logic                       tmo_hit;

`ifdef DEBUG_UNIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             in_load;

  assign in_load = (state_q == LOAD_CNT) || (state_q == LOAD_DATA);

  // Counts idle cycles between load bytes; any byte restarts it.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                         tmo_cnt_q <= '0;
    else if (!in_load || bus.i_rx_valid)  tmo_cnt_q <= '0;
    else                                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign tmo_hit = in_load && !bus.i_rx_valid &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      imem_data_q <= '0;
      waddr_q     <= '0;
      wen_q       <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b0;
      word_q      <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      nwords_q    <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      imem_data_q <= imem_data_d;
      waddr_q     <= waddr_d;
      wen_q       <= wen_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_q   <= cpu_rst_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      nwords_q    <= nwords_d;
    end
  end

  // All outputs are registered: the *_d values computed here show up on the
  // pins the cycle after the triggering input. The status byte is loaded into
  // tx_data on entry to SEND; tx_start is normally raised on entry too, so it
  // is high during the SEND cycle. Load completion enters SEND without it
  // (that cycle carries the last imem write) and SEND raises it one cycle
  // later, keeping the ACK strictly after the final write.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    imem_data_d = imem_data_q;
    waddr_d     = waddr_q;
    wen_d       = 1'b0;
    cpu_en_d    = 1'b0;
    cpu_rst_d   = 1'b0;
    word_d      = word_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    nwords_d    = nwords_q;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_LOAD: state_d = LOAD_CNT;
            CMD_STEP: begin state_d = STEP;    cpu_en_d  = 1'b1; end
            CMD_RUN:  begin state_d = RUN;     cpu_en_d  = 1'b1; end
            CMD_RST:  begin state_d = CPU_RST; cpu_rst_d = 1'b1; end
            default: begin
              state_d    = SEND;
              tx_data_d  = NAK;
              tx_start_d = 1'b1;
            end
          endcase
        end
      end

      LOAD_CNT: begin
        if (tmo_hit) begin
          state_d    = SEND;
          tx_data_d  = NAK;
          tx_start_d = 1'b1;
        end else if (bus.i_rx_valid) begin
          if (bus.i_rx_data == 8'd0 || int'(bus.i_rx_data) > MAX_WORDS) begin
            state_d    = SEND;
            tx_data_d  = NAK;
            tx_start_d = 1'b1;
          end else begin
            nwords_d = bus.i_rx_data;
            idx_d    = '0;
            bcnt_d   = '0;
            word_d   = '0;
            state_d  = LOAD_DATA;
          end
        end
      end

      LOAD_DATA: begin
        if (tmo_hit) begin
          state_d    = SEND;
          tx_data_d  = NAK;
          tx_start_d = 1'b1;
        end else if (bus.i_rx_valid) begin
          // Little-endian: byte 0 lands in [7:0].
          word_d[{bcnt_q, 3'b000} +: 8] = bus.i_rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d       = 1'b1;
            imem_data_d = word_d;
            waddr_d     = IMEM_ADDR_WIDTH'({idx_q, 2'b00});
            idx_d       = idx_q + 8'd1;
            if (idx_q == nwords_q - 8'd1) begin
              state_d   = SEND;
              tx_data_d = ACK;
            end
          end
        end
      end

      STEP: begin
        state_d    = SEND;
        tx_data_d  = ACK;
        tx_start_d = 1'b1;
      end

      RUN: begin
        if (bus.i_halt || (bus.i_rx_valid && bus.i_rx_data == BRK)) begin
          state_d    = SEND;
          tx_data_d  = HALTED;
          tx_start_d = 1'b1;
        end else begin
          cpu_en_d = 1'b1;
        end
      end

      CPU_RST: begin
        state_d    = SEND;
        tx_data_d  = ACK;
        tx_start_d = 1'b1;
      end

      SEND: begin
        if (tx_start_q) state_d = WAIT_TX;
        else            tx_start_d = 1'b1;
      end

      WAIT_TX: begin
        if (bus.i_tx_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_imem_data  = imem_data_q;
  assign bus.o_imem_waddr = waddr_q;
  assign bus.o_mem_wsize  = 2'b10;
  assign bus.o_imem_wen   = wen_q;
  assign bus.o_cpu_en     = cpu_en_q;
  assign bus.o_cpu_rst    = cpu_rst_q;
  assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl. Directed command sequence with
// random payloads, delays and noise bytes; expected responses come from the
// command rules (status byte per command, imem writes derived from the byte
// list, enable length derived from the stop delay). A negedge monitor logs
// all output activity; the stimulus block compares log deltas per command.
// Build with DEBUG_UNIT_TIMEOUT_EN to exercise the load timeout.
module tb_debug_unit_ctrl;
  localparam int AW  = 8;
  localparam int MAXW = (2**AW) / 4;
`ifdef DEBUG_UNIT_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1000000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_unit_ctrl_if #(.NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(AW)) bus ();

  debug_unit_ctrl #(
    .NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  // ---------------- output monitor ----------------
  logic [7:0]    tx_log [0:255];
  logic [AW-1:0] wa_log [0:1023];
  logic [31:0]   wd_log [0:1023];
  int tx_n = 0, wr_n = 0, en_cycles = 0, en_rises = 0, rst_cycles = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      if (tx_n < 256) tx_log[tx_n] <= bus.o_tx_data;
      tx_n <= tx_n + 1;
    end
    if (bus.o_imem_wen) begin
      if (wr_n < 1024) begin
        wa_log[wr_n] <= bus.o_imem_waddr;
        wd_log[wr_n] <= bus.o_imem_data;
      end
      wr_n <= wr_n + 1;
    end
    if (bus.o_cpu_en) en_cycles <= en_cycles + 1;
    if (bus.o_cpu_en && !en_prev) en_rises <= en_rises + 1;
    en_prev <= bus.o_cpu_en;
    if (bus.o_cpu_rst) rst_cycles <= rst_cycles + 1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0, passed = 0;
  int b_tx, b_wr, b_en, b_rise, b_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic begin_cmd();
    #1;
    b_tx = tx_n; b_wr = wr_n; b_en = en_cycles; b_rise = en_rises; b_rst = rst_cycles;
  endtask

  // Caller is at a negedge; byte is sampled at the next posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  // Waits (bounded) for the status byte, optionally injects a byte that must
  // be ignored, then acknowledges the transmission.
  task automatic finish_cmd(input string tag, input bit noise);
    bit seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      if (bus.o_tx_start) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, ":tx_start_seen"}, 32'(seen), 1);
    bus.i_halt = 1'b0;
    if (noise) send_byte(8'h53);
    else @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({tag, ":busy_before_done"}, 32'(bus.o_busy), 1);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check({tag, ":busy_after_done"}, 32'(bus.o_busy), 0);
  endtask

  task automatic check_resp(input string tag, input logic [7:0] exp_tx,
                            input int exp_wr, input int exp_en, input int exp_rst);
    #1;
    check({tag, ":tx_count"}, 32'(tx_n - b_tx), 1);
    check({tag, ":tx_byte"}, 32'(tx_log[b_tx]), 32'(exp_tx));
    check({tag, ":wr_count"}, 32'(wr_n - b_wr), 32'(exp_wr));
    check({tag, ":en_cycles"}, 32'(en_cycles - b_en), 32'(exp_en));
    check({tag, ":en_pulses"}, 32'(en_rises - b_rise), (exp_en > 0) ? 32'd1 : 32'd0);
    check({tag, ":rst_cycles"}, 32'(rst_cycles - b_rst), 32'(exp_rst));
  endtask

  // Reference for a load: accepted iff 1 <= n <= MAXW; word i is bytes
  // 4i..4i+3 little-endian at byte address 4i.
  task automatic do_load(input string tag, input int n, input logic [7:0] pay[$], input bit gaps);
    logic [7:0] bytes[$];
    bit ok;
    int nb;
    logic [31:0] w;
    ok = (n >= 1) && (n <= MAXW);
    nb = ok ? 4 * n : 0;
    for (int i = 0; i < nb; i++)
      bytes.push_back((i < pay.size()) ? pay[i] : 8'($urandom));
    begin_cmd();
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    finish_cmd(tag, 1'b0);
    check_resp(tag, ok ? 8'h06 : 8'h15, ok ? n : 0, 0, 0);
    for (int i = 0; i < n && ok; i++) begin
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      check({tag, ":waddr"}, 32'(wa_log[b_wr + i]), (4 * i) % (2**AW));
      check({tag, ":wdata"}, wd_log[b_wr + i], w);
    end
  endtask

  // Run: the core stays enabled from the cycle after 'C' up to and including
  // the cycle in which the stop condition is first sampled -> d+1 cycles.
  task automatic do_run(input string tag, input int d, input bit brk, input bit noise);
    begin_cmd();
    send_byte(8'h43);
    for (int j = 0; j < d; j++) begin
      if (noise && j == d / 2) send_byte(8'h53);
      else @(negedge clk);
    end
    if (brk) send_byte(8'h03);
    else bus.i_halt = 1'b1;
    finish_cmd(tag, 1'b0);
    check_resp(tag, 8'h48, 0, d + 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] none[$];
    int d;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_halt     = 1'b0;
    bus.i_tx_done  = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst:tx_start", 32'(bus.o_tx_start), 0);
    check("rst:tx_data", 32'(bus.o_tx_data), 0);
    check("rst:wen", 32'(bus.o_imem_wen), 0);
    check("rst:imem_data", bus.o_imem_data, 0);
    check("rst:waddr", 32'(bus.o_imem_waddr), 0);
    check("rst:wsize", 32'(bus.o_mem_wsize), 2);
    check("rst:cpu_en", 32'(bus.o_cpu_en), 0);
    check("rst:cpu_rst", 32'(bus.o_cpu_rst), 0);
    check("rst:busy", 32'(bus.o_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed load from the test plan
    pay = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    do_load("load2", 2, pay, 1'b0);
    check("load2:word0", wd_log[b_wr], 32'h0050_0013);
    check("load2:word1", wd_log[b_wr + 1], 32'h00A0_0093);

    // random loads, with and without gaps, plus full-capacity load
    for (int r = 0; r < 3; r++) do_load("load_rand", $urandom_range(1, 8), none, r[0]);
    do_load("load_max", MAXW, none, 1'b0);

    // rejected counts
    do_load("load_zero", 0, none, 1'b0);
    do_load("load_over", MAXW + 1, none, 1'b0);
    do_load("load_ff", 255, none, 1'b0);

    // single step
    begin_cmd(); send_byte(8'h53); finish_cmd("step", 1'b0);
    check_resp("step", 8'h06, 0, 1, 0);

    // run until halt, until break (with ignored noise), halt already high
    do_run("run_halt50", 50, 1'b0, 1'b0);
    d = $urandom_range(4, 40);
    do_run("run_break", d, 1'b1, 1'b1);
    bus.i_halt = 1'b1;
    do_run("run_prehalt", 0, 1'b0, 1'b0);

    // unknown commands
    begin_cmd(); send_byte(8'h5A); finish_cmd("cmd_z", 1'b0);
    check_resp("cmd_z", 8'h15, 0, 0, 0);
    begin_cmd(); send_byte(8'h03); finish_cmd("cmd_brk_idle", 1'b0);
    check_resp("cmd_brk_idle", 8'h15, 0, 0, 0);

    // core reset, with a byte arriving in WAIT_TX that must be dropped
    begin_cmd(); send_byte(8'h52); finish_cmd("cpu_rst", 1'b1);
    check_resp("cpu_rst", 8'h06, 0, 0, 1);

    // reset in the middle of a load
    begin_cmd();
    send_byte(8'h4C); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("midrst:busy", 32'(bus.o_busy), 0);
    check("midrst:tx_data", 32'(bus.o_tx_data), 0);
    check("midrst:cpu_en", 32'(bus.o_cpu_en), 0);
    check("midrst:wen", 32'(bus.o_imem_wen), 0);
    check("midrst:wsize", 32'(bus.o_mem_wsize), 2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst:no_write", 32'(wr_n - b_wr), 0);
    begin_cmd(); send_byte(8'h53); finish_cmd("post_rst_step", 1'b0);
    check_resp("post_rst_step", 8'h06, 0, 1, 0);

    // stalled load: one full word, then one byte, then silence
    begin_cmd();
    send_byte(8'h4C); send_byte(8'h02);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (pay[i]) send_byte(pay[i]);
`ifdef DEBUG_UNIT_TIMEOUT_EN
    begin
      int k;
      for (k = 0; k < 400; k++) begin
        if (bus.o_tx_start) break;
        @(negedge clk);
      end
      check("tmo:latency", 32'(k), 32'(TMO));
    end
    finish_cmd("tmo", 1'b0);
    check_resp("tmo", 8'h15, 1, 0, 0);
    check("tmo:kept_word", wd_log[b_wr], 32'h4433_2211);
`else
    repeat (300) @(negedge clk);
    check("stall:no_tx", 32'(tx_n - b_tx), 0);
    check("stall:busy", 32'(bus.o_busy), 1);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    finish_cmd("stall", 1'b0);
    check_resp("stall", 8'h06, 2, 0, 0);
    check("stall:word1", wd_log[b_wr + 1], 32'h8877_6655);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/debug_unit_ctrl.md
# debug_unit_ctrl

Debug-unit controller sitting beside `cpu_core` in `cpu_subsystem`. It consumes a byte stream from the UART receiver and sequences the CPU through four operations: program load into instruction memory, single step, continuous run until halt, and core reset. It drives the core's existing `i_imem_*`/`i_en`/`i_rst` ports and returns one status byte per command to the UART transmitter.

## Interface
- `NB_INSTRUCTION`, 32: instruction word width; fixed 4 bytes per word.
- `IMEM_ADDR_WIDTH`, 8: instruction memory byte-address width; capacity `MAX_WORDS = 2**IMEM_ADDR_WIDTH/4`.
- `TIMEOUT_CYCLES`, 1000000: inter-byte load timeout; used only with the macro.
- `clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` valid.
- `i_halt`  in  1  core reached end of program; level.
- `i_tx_done`  in  1  one-cycle strobe; transmitter finished the byte.
- `o_tx_data`  out  8  status byte.
- `o_tx_start`  out  1  one-cycle strobe launching `o_tx_data`.
- `o_imem_data`  out  `NB_INSTRUCTION`  assembled word.
- `o_imem_waddr`  out  `IMEM_ADDR_WIDTH`  byte address of the word.
- `o_mem_wsize`  out  2  constant 2'b10 (word).
- `o_imem_wen`  out  1  one-cycle write strobe.
- `o_cpu_en`  out  1  core enable.
- `o_cpu_rst`  out  1  core reset, active-high, one-cycle pulse.
- `o_busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, LOAD_CNT, LOAD_DATA, STEP, RUN, CPU_RST, SEND, WAIT_TX.
- IDLE accepts a command byte: 0x4C 'L' -> LOAD_CNT; 0x53 'S' -> STEP; 0x43 'C' -> RUN; 0x52 'R' -> CPU_RST; any other value -> SEND with NAK 0x15.
- LOAD_CNT: the next byte is word count N. If N==0 or N>MAX_WORDS, go to SEND with NAK. Otherwise clear the word index and byte counter and go to LOAD_DATA.
- LOAD_DATA: bytes arrive little-endian, first byte into [7:0]. On the 4th byte, write `o_imem_data` with `o_imem_waddr = 4*index` (index truncated to the address width). After word N, go to SEND with ACK 0x06.
- STEP: `o_cpu_en` high exactly one cycle, then SEND ACK.
- RUN: `o_cpu_en` held high until `i_halt`=1 or a received byte 0x03 (break), then drop it and go to SEND with 0x48 'H'. If `i_halt` is already high on entry, `o_cpu_en` still pulses one cycle.
- CPU_RST: `o_cpu_rst` one-cycle pulse, then SEND ACK.
- SEND: `o_tx_start` high one cycle with `o_tx_data` stable, then WAIT_TX. WAIT_TX returns to IDLE on `i_tx_done`. `o_tx_data` holds until the next SEND.
- RX bytes arriving in STEP, CPU_RST, SEND or WAIT_TX are dropped. In RUN, only 0x03 is acted on.
- Reset (async, any state): all outputs 0 except `o_mem_wsize`=2'b10; state IDLE; counters and the word register cleared. A load interrupted by reset writes nothing further.

## Timing
- Registered outputs: each response appears the cycle after the triggering `i_rx_valid` edge.
- `o_imem_wen` asserts in cycle k+1 when the 4th byte arrives in cycle k. `o_imem_data` and `o_imem_waddr` are valid in that same cycle.
- ACK `o_tx_start` follows the last `o_imem_wen` by one cycle.
- `i_rx_valid` is accepted on back-to-back cycles in LOAD_DATA with no dropped bytes.
- In RUN, `o_cpu_en` falls the cycle after `i_halt` is sampled high.

## Configuration
- `DEBUG_UNIT_TIMEOUT_EN` defined: a counter in LOAD_CNT and LOAD_DATA restarts on every `i_rx_valid`. When it reaches `TIMEOUT_CYCLES` with no byte, the block goes to SEND with NAK 0x15. Words already written stay written.
- Undefined: no counter; the block waits indefinitely for load bytes.

## Test plan
- Reset, then 'L', 0x02, bytes 13 00 50 00 93 00 A0 00 -> wen at addr 0x00 data 0x00500013, then addr 0x04 data 0x00A00093; TX 0x06; o_busy falls after i_tx_done.
- 'L', 0x00 and 'L', 0x41 (MAX_WORDS=64) -> no wen; TX 0x15 each.
- 'S' -> o_cpu_en high exactly 1 cycle; TX 0x06.
- 'C', i_halt raised 50 cycles later -> o_cpu_en high for those cycles, drops next cycle; TX 0x48. Repeat with 0x03 byte instead of i_halt -> same response.
- 'Z' -> TX 0x15, no other output activity. 'R' -> one o_cpu_rst pulse, TX 0x06.
- i_rst_n low mid-LOAD_DATA after 2 bytes -> outputs cleared immediately; post-reset 'S' works. With the macro and TIMEOUT_CYCLES=100, a stalled load gives NAK after 100 idle cycles.
